lieat_general_radix_4_otfc: RTL and testbench
=============================================

Name: lieat_general_radix_4_otfc

Overview:
- Sequential on-the-fly-conversion (OTFC) stage directly downstream of the radix-4 quotient sign coder in the SRT divider.
- Each accepted iteration consumes one one-hot quotient digit in {-2,-1,0,+1,+2} and updates two registers, Q and QM = Q - 1 ulp, with no carry-propagate adder.
- After the programmed number of digits it flags completion and holds the final Q/QM for the divider's rounding/result stage.

Parameters:
- QUOT_W, 54, width of the Q/QM registers in bits. Must be even and >= 4.
- ITER_NUM, QUOT_W/2, number of radix-4 digits accepted per operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start_i  input  1  begin a new operation: clear Q, set QM to all-ones.
- quot_vld_i  input  1  quot_i carries a valid digit this cycle.
- quot_i  input  5  one-hot digit. Bit 0 = -2, bit 1 = -1, bit 2 = 0, bit 3 = +1, bit 4 = +2.
- quot_o  output  QUOT_W  accumulated quotient Q.
- quot_m1_o  output  QUOT_W  accumulated Q - 1 ulp (QM).
- busy_o  output  1  high while in RUN.
- done_o  output  1  one-cycle completion pulse.
- err_o  output  1  sticky flag for a non-one-hot quot_i while a digit is accepted.

Behaviour:
- Reset (rst=1 at an edge) overrides all other inputs:
  - state=IDLE, Q=0, QM=0, counter=0, busy_o=0, done_o=0, err_o=0.
- States:
  - IDLE: quot_vld_i is ignored. start_i -> RUN, with Q=0, QM={QUOT_W{1}}, counter=0, err_o=0.
  - RUN: a digit is accepted on each edge with quot_vld_i=1. Q/QM update at that edge and counter increments. When the ITER_NUM-th digit is accepted -> DONE.
  - DONE: lasts exactly one cycle with done_o=1, then -> IDLE. start_i in DONE is honoured as in IDLE (-> RUN, done_o still 1 this cycle).
  - start_i in RUN aborts the current operation and reinitialises exactly as from IDLE. Any simultaneous quot_vld_i is discarded.
- Digit update rules, using the current Q/QM. "<<2" means shift left by 2 keeping the low QUOT_W bits; "|" means OR into bits [1:0].
  - +2: Q'=Q<<2|2'b10, QM'=Q<<2|2'b01.
  - +1: Q'=Q<<2|2'b01, QM'=Q<<2|2'b00.
  - 0: Q'=Q<<2|2'b00, QM'=QM<<2|2'b11.
  - -1: Q'=QM<<2|2'b11, QM'=QM<<2|2'b10.
  - -2: Q'=QM<<2|2'b10, QM'=QM<<2|2'b01.
- Illegal quot_i (zero or more than one bit set) on an accepted edge:
  - Q/QM hold and the counter still increments.
  - err_o is set and stays 1 until the next start_i or rst.
- Gaps in quot_vld_i during RUN are allowed; Q/QM and the counter hold.
- Latency: outputs reflect an accepted digit one cycle after the accepting edge. done_o is high in the cycle after the last digit is accepted.
- quot_o/quot_m1_o hold their final values through DONE and IDLE until the next start_i or rst.
- busy_o = (state==RUN), registered. The counter width is clog2(ITER_NUM+1).

Test Plan:
- Reset: QUOT_W=8. Assert rst for 2 cycles mid-RUN -> quot_o=0x00, quot_m1_o=0x00, busy_o=0, done_o=0, err_o=0, state IDLE.
- Mixed digits: QUOT_W=8, start, digits +2,+1,0,-1 on consecutive cycles.
  - Q/QM after each digit: 02/01, 09/08, 24/23, 8F/8E.
  - done_o pulses once, one cycle after the 4th digit.
  - busy_o=1 for exactly 4 cycles.
- All -2 with gaps: QUOT_W=8, start, four -2 digits with quot_vld_i low between them.
  - Q sequence: FE, F6, D6, 56. Final quot_o=0x56 (-170 mod 256), quot_m1_o=0x55.
  - Q/QM hold during gaps.
- Abort and restart: QUOT_W=8, start, two +1 digits, then start_i with quot_vld_i=1 and quot_i=+2.
  - Next cycle Q=0x00, QM=0xFF, counter=0. The +2 digit is discarded and no done_o occurs.
- Illegal digit: during RUN, quot_i=5'b00000 with quot_vld_i=1.
  - Q/QM unchanged, err_o=1, completion still after ITER_NUM accepts.
  - err_o clears on the next start_i.
- Back-to-back operations with default QUOT_W=54: 27 digits of +1.
  - quot_o=0x15555555555555, quot_m1_o=0x15555555555554, done_o pulse.
  - start_i in the DONE cycle begins the next operation with no idle cycle.

Source files
------------

// File: rtl/lieat_general_radix_4_otfc.sv
// Radix-4 on-the-fly quotient conversion stage for the SRT divider.
// Keeps Q and QM = Q - 1 ulp so that each signed digit in {-2..+2} is absorbed by a
// shift and a 2-bit append, with no carry-propagate adder anywhere in the loop.
module lieat_general_radix_4_otfc #(
  parameter int unsigned QUOT_W   = 54,
  parameter int unsigned ITER_NUM = QUOT_W / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              quot_vld_i,
  input  logic [4:0]        quot_i,
  output logic [QUOT_W-1:0] quot_o,
  output logic [QUOT_W-1:0] quot_m1_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned CntW = $clog2(ITER_NUM + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(ITER_NUM - 1);

  // One-hot digit encodings as delivered by the quotient sign coder.
  localparam logic [4:0] DigM2 = 5'b00001;
  localparam logic [4:0] DigM1 = 5'b00010;
  localparam logic [4:0] DigZ  = 5'b00100;
  localparam logic [4:0] DigP1 = 5'b01000;
  localparam logic [4:0] DigP2 = 5'b10000;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [QUOT_W-1:0] q_q, q_d;
  logic [QUOT_W-1:0] qm_q, qm_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [QUOT_W-1:0] q_sh, qm_sh;
  logic [QUOT_W-1:0] q_upd, qm_upd;
  logic              digit_legal;

  assign q_sh  = q_q << 2;
  assign qm_sh = qm_q << 2;

  // Digit decode: choose the shifted source (Q or QM) and the appended 2-bit pattern.
  always_comb begin
    q_upd       = q_q;
    qm_upd      = qm_q;
    digit_legal = 1'b1;
    unique case (quot_i)
      DigP2: begin
        q_upd  = q_sh | QUOT_W'(2'b10);
        qm_upd = q_sh | QUOT_W'(2'b01);
      end
      DigP1: begin
        q_upd  = q_sh | QUOT_W'(2'b01);
        qm_upd = q_sh;
      end
      DigZ: begin
        q_upd  = q_sh;
        qm_upd = qm_sh | QUOT_W'(2'b11);
      end
      DigM1: begin
        q_upd  = qm_sh | QUOT_W'(2'b11);
        qm_upd = qm_sh | QUOT_W'(2'b10);
      end
      DigM2: begin
        q_upd  = qm_sh | QUOT_W'(2'b10);
        qm_upd = qm_sh | QUOT_W'(2'b01);
      end
      default: begin
        // Zero or multiple bits set: registers hold, error is flagged.
        digit_legal = 1'b0;
      end
    endcase
  end

  // Next-state logic: start always (re)initialises; digits are only taken in RUN.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    qm_d    = qm_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          q_d     = '0;
          qm_d    = '1;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      StRun: begin
        if (start_i) begin
          // Abort: a digit presented in the same cycle is discarded.
          state_d = StRun;
          q_d     = '0;
          qm_d    = '1;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (quot_vld_i) begin
          cnt_d = cnt_q + 1'b1;
          if (digit_legal) begin
            q_d  = q_upd;
            qm_d = qm_upd;
          end else begin
            err_d = 1'b1;
          end
          if (cnt_q == LastCnt) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (start_i) begin
          state_d = StRun;
          q_d     = '0;
          qm_d    = '1;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      q_q     <= '0;
      qm_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign quot_o    = q_q;
  assign quot_m1_o = qm_q;
  assign busy_o    = (state_q == StRun);
  assign done_o    = (state_q == StDone);
  assign err_o     = err_q;

endmodule

// File: tb/tb_lieat_general_radix_4_otfc.sv
// Directed bench for the radix-4 OTFC stage: an 8-bit instance driven from a vector table
// and a default 54-bit instance exercised with hand-written back-to-back operations.
module tb_lieat_general_radix_4_otfc;

  localparam logic [4:0] DM2 = 5'b00001;
  localparam logic [4:0] DM1 = 5'b00010;
  localparam logic [4:0] DZ  = 5'b00100;
  localparam logic [4:0] DP1 = 5'b01000;
  localparam logic [4:0] DP2 = 5'b10000;
  localparam logic [4:0] DBAD0 = 5'b00000;
  localparam logic [4:0] DBAD2 = 5'b00011;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        quot_vld_i;
  logic [4:0]  quot_i;

  logic [7:0]  q8, qm8;
  logic        busy8, done8, err8;
  logic [53:0] q54, qm54;
  logic        busy54, done54, err54;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lieat_general_radix_4_otfc #(.QUOT_W(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .quot_vld_i(quot_vld_i),
    .quot_i    (quot_i),
    .quot_o    (q8),
    .quot_m1_o (qm8),
    .busy_o    (busy8),
    .done_o    (done8),
    .err_o     (err8)
  );

  lieat_general_radix_4_otfc u_dut54 (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .quot_vld_i(quot_vld_i),
    .quot_i    (quot_i),
    .quot_o    (q54),
    .quot_m1_o (qm54),
    .busy_o    (busy54),
    .done_o    (done54),
    .err_o     (err54)
  );

  typedef struct {
    logic       start;
    logic       vld;
    logic [4:0] digit;
    logic [7:0] exp_q;
    logic [7:0] exp_qm;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t row(input logic s, input logic v, input logic [4:0] d,
                               input logic [7:0] q, input logic [7:0] qm,
                               input logic b, input logic dn, input logic e);
    vec_t r;
    r.start = s; r.vld = v; r.digit = d;
    r.exp_q = q; r.exp_qm = qm; r.exp_busy = b; r.exp_done = dn; r.exp_err = e;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic v, input logic [4:0] d);
    start_i    = s;
    quot_vld_i = v;
    quot_i     = d;
  endtask

  initial begin
    int done_seen;
    rst = 1'b1;
    drive(1'b0, 1'b0, DZ);
    step();
    step();
    check("por_q8", q8, 8'h00);
    check("por_qm8", qm8, 8'h00);
    check("por_busy8", busy8, 1'b0);
    check("por_done8", done8, 1'b0);
    check("por_err8", err8, 1'b0);
    rst = 1'b0;

    // Reset mid-RUN, with an error already latched and inputs active.
    drive(1'b1, 1'b0, DZ);   step();
    drive(1'b0, 1'b1, DP1);  step();
    drive(1'b0, 1'b1, DBAD0); step();
    check("pre_rst_err8", err8, 1'b1);
    check("pre_rst_busy8", busy8, 1'b1);
    rst = 1'b1;
    drive(1'b1, 1'b1, DP2);
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, DZ);
    check("rst_q8", q8, 8'h00);
    check("rst_qm8", qm8, 8'h00);
    check("rst_busy8", busy8, 1'b0);
    check("rst_done8", done8, 1'b0);
    check("rst_err8", err8, 1'b0);
    check("rst_q54", q54, 64'h0);
    check("rst_qm54", qm54, 64'h0);
    step();
    check("rst_idle_busy8", busy8, 1'b0);
    check("rst_idle_q8", q8, 8'h00);

    //            start vld  digit  Q      QM     busy done err
    // Mixed digits +2,+1,0,-1
    vq.push_back(row(1, 0, DZ,  8'h00, 8'hFF, 1, 0, 0));
    vq.push_back(row(0, 1, DP2, 8'h02, 8'h01, 1, 0, 0));
    vq.push_back(row(0, 1, DP1, 8'h09, 8'h08, 1, 0, 0));
    vq.push_back(row(0, 1, DZ,  8'h24, 8'h23, 1, 0, 0));
    vq.push_back(row(0, 1, DM1, 8'h8F, 8'h8E, 0, 1, 0));
    vq.push_back(row(0, 0, DZ,  8'h8F, 8'h8E, 0, 0, 0));
    // Digit in IDLE is ignored
    vq.push_back(row(0, 1, DP2, 8'h8F, 8'h8E, 0, 0, 0));
    // All -2 with gaps
    vq.push_back(row(1, 0, DZ,  8'h00, 8'hFF, 1, 0, 0));
    vq.push_back(row(0, 1, DM2, 8'hFE, 8'hFD, 1, 0, 0));
    vq.push_back(row(0, 0, DM2, 8'hFE, 8'hFD, 1, 0, 0));
    vq.push_back(row(0, 1, DM2, 8'hF6, 8'hF5, 1, 0, 0));
    vq.push_back(row(0, 0, DM2, 8'hF6, 8'hF5, 1, 0, 0));
    vq.push_back(row(0, 1, DM2, 8'hD6, 8'hD5, 1, 0, 0));
    vq.push_back(row(0, 0, DBAD0, 8'hD6, 8'hD5, 1, 0, 0));
    vq.push_back(row(0, 1, DM2, 8'h56, 8'h55, 0, 1, 0));
    vq.push_back(row(0, 0, DZ,  8'h56, 8'h55, 0, 0, 0));
    // Illegal digits: hold, count, sticky error
    vq.push_back(row(1, 0, DZ,  8'h00, 8'hFF, 1, 0, 0));
    vq.push_back(row(0, 1, DP1, 8'h01, 8'h00, 1, 0, 0));
    vq.push_back(row(0, 1, DBAD0, 8'h01, 8'h00, 1, 0, 1));
    vq.push_back(row(0, 1, DBAD2, 8'h01, 8'h00, 1, 0, 1));
    vq.push_back(row(0, 1, DP1, 8'h05, 8'h04, 0, 1, 1));
    vq.push_back(row(0, 0, DZ,  8'h05, 8'h04, 0, 0, 1));
    vq.push_back(row(1, 0, DZ,  8'h00, 8'hFF, 1, 0, 0));
    // Abort with a simultaneous digit, then a clean run
    vq.push_back(row(0, 1, DP1, 8'h01, 8'h00, 1, 0, 0));
    vq.push_back(row(0, 1, DP1, 8'h05, 8'h04, 1, 0, 0));
    vq.push_back(row(1, 1, DP2, 8'h00, 8'hFF, 1, 0, 0));
    vq.push_back(row(0, 1, DP1, 8'h01, 8'h00, 1, 0, 0));
    vq.push_back(row(0, 1, DP1, 8'h05, 8'h04, 1, 0, 0));
    vq.push_back(row(0, 1, DP1, 8'h15, 8'h14, 1, 0, 0));
    vq.push_back(row(0, 1, DP1, 8'h55, 8'h54, 0, 1, 0));
    vq.push_back(row(0, 0, DZ,  8'h55, 8'h54, 0, 0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].start, vq[i].vld, vq[i].digit);
      step();
      check($sformatf("vec%0d_q", i), q8, vq[i].exp_q);
      check($sformatf("vec%0d_qm", i), qm8, vq[i].exp_qm);
      check($sformatf("vec%0d_busy", i), busy8, vq[i].exp_busy);
      check($sformatf("vec%0d_done", i), done8, vq[i].exp_done);
      check($sformatf("vec%0d_err", i), err8, vq[i].exp_err);
    end

    // 54-bit: 27 digits of +1, then start in the DONE cycle, then 27 digits of +2.
    drive(1'b1, 1'b0, DZ);
    step();
    check("w54_start_q", q54, 64'h0);
    check("w54_start_qm", qm54, 64'h3F_FFFF_FFFF_FFFF);
    done_seen = 0;
    for (int i = 0; i < 27; i++) begin
      drive(1'b0, 1'b1, DP1);
      step();
      if (done54) done_seen++;
    end
    check("w54_op1_done_cnt", done_seen, 1);
    check("w54_op1_done", done54, 1'b1);
    check("w54_op1_busy", busy54, 1'b0);
    check("w54_op1_q", q54, 64'h15_5555_5555_5555);
    check("w54_op1_qm", qm54, 64'h15_5555_5555_5554);
    drive(1'b1, 1'b0, DZ);
    step();
    check("w54_b2b_busy", busy54, 1'b1);
    check("w54_b2b_done", done54, 1'b0);
    check("w54_b2b_q", q54, 64'h0);
    check("w54_b2b_qm", qm54, 64'h3F_FFFF_FFFF_FFFF);
    done_seen = 0;
    for (int i = 0; i < 27; i++) begin
      drive(1'b0, 1'b1, DP2);
      step();
      if (done54) done_seen++;
    end
    check("w54_op2_done_cnt", done_seen, 1);
    check("w54_op2_done", done54, 1'b1);
    check("w54_op2_q", q54, 64'h2A_AAAA_AAAA_AAAA);
    check("w54_op2_qm", qm54, 64'h2A_AAAA_AAAA_AAA9);
    check("w54_op2_err", err54, 1'b0);
    drive(1'b0, 1'b0, DZ);
    step();
    check("w54_hold_done", done54, 1'b0);
    check("w54_hold_q", q54, 64'h2A_AAAA_AAAA_AAAA);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
